// File: rtl/regfile_mem_pkg.sv
// regfile_mem_pkg: shared types, constants and lane-mask helper for regfile_mem
package regfile_mem_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int ZERO_ADDR = 0;
  localparam int MAX_D = 1024;
  localparam int MAX_B = MAX_D / 8;
  // widest supported mask; callers cast down to their own data width
  function automatic logic [MAX_D-1:0] lane_mask(input logic [MAX_B-1:0] be);
    for (int i = 0; i < MAX_B; i++) lane_mask[8*i +: 8] = {8{be[i]}};
  endfunction
endpackage

// File: rtl/regfile_mem_if.sv
// regfile_mem_if: write/read port bundle of regfile_mem
interface regfile_mem_if #(parameter int A = 8, parameter int D = 8);
  logic ce;
  logic we;
  logic [D/8-1:0] be;
  logic [A-1:0] waddr;
  logic [D-1:0] wdata;
  logic [A-1:0] ra_addr;
  logic [A-1:0] rb_addr;
  logic [D-1:0] qa;
  logic [D-1:0] qb;
  logic busy;
  modport master(output ce, we, be, waddr, wdata, ra_addr, rb_addr, input qa, qb, busy);
  modport slave(input ce, we, be, waddr, wdata, ra_addr, rb_addr, output qa, qb, busy);
endinterface

// File: rtl/regfile_mem_clear.sv
// regfile_mem_clear: post-reset sweep that zeroes addresses 1..R-1, then stays READY
module regfile_mem_clear
  import regfile_mem_pkg::*;
#(
  parameter int A = 8,
  parameter int R = 256
) (
  input  logic         clk,
  input  logic         rst,
  output logic         busy,
  output logic         clear_we,
  output logic [A-1:0] clear_addr
);
  localparam logic [0:0] S_CLEAR = 1'(CLEAR);
  localparam logic [0:0] S_READY = 1'(READY);
  localparam logic [A-1:0] LAST = A'(R - 1);
  logic [0:0] state;
  logic [A-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt <= A'(1);
    end else if (state == S_CLEAR) begin
      cnt <= (cnt == LAST) ? cnt : cnt + A'(1);
      state <= (cnt == LAST) ? S_READY : S_CLEAR;
    end
  end
  assign busy = state == S_CLEAR;
  assign clear_we = busy;
  assign clear_addr = cnt;
endmodule

// File: rtl/regfile_mem.sv
// regfile_mem: 1W/2R register file, address 0 reads zero, byte-lane writes, write-first bypass.
// Define REGFILE_MEM_CLEAR_EN to add the post-reset clear sweep (busy high while it runs).
module regfile_mem
  import regfile_mem_pkg::*;
#(
  parameter int A = 8,
  parameter int D = 8,
  parameter int R = 256
) (
  input logic clk,
  input logic rst,
  regfile_mem_if.slave bus
);
  logic [D-1:0] mem [R];
  logic busy, clear_we;
  logic [A-1:0] clear_addr;
`ifdef REGFILE_MEM_CLEAR_EN
  regfile_mem_clear #(.A(A), .R(R)) u_clear (
    .clk(clk),
    .rst(rst),
    .busy(busy),
    .clear_we(clear_we),
    .clear_addr(clear_addr)
  );
`else
  assign busy = 1'b0;
  assign clear_we = 1'b0;
  assign clear_addr = '0;
`endif
  logic en, user_we, wr_en;
  logic [D-1:0] mask, merged, wr_data, rd_a, rd_b;
  logic [A-1:0] wr_addr;
  assign en = bus.ce & ~busy;
  assign user_we = en & bus.we & (bus.waddr != A'(ZERO_ADDR));
  assign mask = D'(lane_mask(MAX_B'(bus.be)));
  assign merged = (mem[bus.waddr] & ~mask) | (bus.wdata & mask);
  // sweep and user writes never coincide: user writes need busy=0
  assign wr_en = ~rst & (clear_we | user_we);
  assign wr_addr = clear_we ? clear_addr : bus.waddr;
  assign wr_data = clear_we ? '0 : merged;
  assign rd_a = (bus.ra_addr == A'(ZERO_ADDR)) ? '0 :
                (user_we && bus.ra_addr == bus.waddr) ? merged : mem[bus.ra_addr];
  assign rd_b = (bus.rb_addr == A'(ZERO_ADDR)) ? '0 :
                (user_we && bus.rb_addr == bus.waddr) ? merged : mem[bus.rb_addr];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.qa <= '0;
      bus.qb <= '0;
    end else if (en) begin
      bus.qa <= rd_a;
      bus.qb <= rd_b;
    end
  end
  assign bus.busy = busy;
endmodule

// File: tb/tb_regfile_mem.sv
// tb_regfile_mem: randomized and directed checks of regfile_mem against a word-array model
module tb_regfile_mem;
  localparam int A = 8;
  localparam int D = 32;
  localparam int R = 256;
`ifdef REGFILE_MEM_CLEAR_EN
  localparam int SWEEP = R - 1;
`else
  localparam int SWEEP = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_mem_if #(.A(A), .D(D)) bus ();
  regfile_mem #(.A(A), .D(D), .R(R)) dut (.clk(clk), .rst(rst), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  logic [D-1:0] mm [R];
  logic [D-1:0] exp_qa = '0;
  logic [D-1:0] exp_qb = '0;
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.ce = 1'b0;
    bus.we = 1'b0;
    bus.be = '0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.ra_addr = '0;
    bus.rb_addr = '0;
  endtask
  task automatic drive(input logic c, input logic w, input logic [3:0] b, input logic [7:0] wa,
                       input logic [7:0] ra, input logic [7:0] rb, input logic [31:0] wd);
    logic [31:0] m, nw;
    bus.ce = c;
    bus.we = w;
    bus.be = b;
    bus.waddr = wa;
    bus.wdata = wd;
    bus.ra_addr = ra;
    bus.rb_addr = rb;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
    nw = (mm[wa] & ~m) | (wd & m);
    if (c) begin
      exp_qa = (ra == 0) ? 32'h0 : (w && wa != 0 && ra == wa) ? nw : mm[ra];
      exp_qb = (rb == 0) ? 32'h0 : (w && wa != 0 && rb == wa) ? nw : mm[rb];
      if (w && wa != 0) mm[wa] = nw;
    end
    cycle();
  endtask
  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle();
    cycle();
    cycle();
    compared++;
    if (bus.qa !== 32'h0 || bus.qb !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_q: qa=%h qb=%h expected 0", bus.qa, bus.qb);
    end
    compared++;
    if (bus.busy !== (SWEEP > 0)) begin
      mismatched++;
      $display("FAIL reset_busy: busy=%b expected %b", bus.busy, SWEEP > 0);
    end
    rst = 1'b0;
`ifdef REGFILE_MEM_CLEAR_EN
    bus.ce = 1'b1;
    bus.we = 1'b1;
    bus.be = 4'hf;
    bus.waddr = 8'd9;
    bus.wdata = 32'hdeadbeef;
    bus.ra_addr = 8'd9;
    bus.rb_addr = 8'd9;
`endif
    n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      cycle();
      n++;
      compared++;
      if (bus.qa !== 32'h0) begin
        mismatched++;
        $display("FAIL busy_hold: cycle %0d qa=%h expected 0", n, bus.qa);
      end
    end
    idle();
    compared++;
    if (n != SWEEP) begin
      mismatched++;
      $display("FAIL busy_cycles: got %0d expected %0d", n, SWEEP);
    end
    for (int i = 0; i < R; i++) mm[i] = '0;
  endtask
  task automatic test_sweep_contents();
`ifdef REGFILE_MEM_CLEAR_EN
    logic [7:0] addrs [4] = '{8'd9, 8'd1, 8'd128, 8'd255};
    for (int i = 0; i < 4; i += 2) begin
      drive(1'b1, 1'b0, 4'h0, 8'd0, addrs[i], addrs[i+1], 32'h0);
      compared++;
      if (bus.qa !== 32'h0 || bus.qb !== 32'h0) begin
        mismatched++;
        $display("FAIL swept_zero: addr %0d/%0d qa=%h qb=%h expected 0", addrs[i], addrs[i+1], bus.qa, bus.qb);
      end
    end
`endif
  endtask
  task automatic test_fill();
    for (int a = 1; a < R; a++) drive(1'b1, 1'b1, 4'hf, 8'(a), 8'd0, 8'd0, $urandom());
  endtask
  task automatic test_zero_addr();
    drive(1'b1, 1'b1, 4'hf, 8'd0, 8'd0, 8'd0, 32'ha5);
    compared++;
    if (bus.qa !== 32'h0 || bus.qb !== 32'h0) begin
      mismatched++;
      $display("FAIL zero_bypass: qa=%h qb=%h expected 0", bus.qa, bus.qb);
    end
    drive(1'b1, 1'b0, 4'h0, 8'd0, 8'd0, 8'd0, 32'h0);
    compared++;
    if (bus.qa !== 32'h0 || bus.qb !== 32'h0) begin
      mismatched++;
      $display("FAIL zero_read: qa=%h qb=%h expected 0", bus.qa, bus.qb);
    end
  endtask
  task automatic test_lanes();
    drive(1'b1, 1'b1, 4'hf, 8'd5, 8'd0, 8'd0, 32'h11223344);
    drive(1'b1, 1'b1, 4'b0101, 8'd5, 8'd0, 8'd0, 32'haabbccdd);
    drive(1'b1, 1'b0, 4'h0, 8'd0, 8'd5, 8'd5, 32'h0);
    compared++;
    if (bus.qa !== 32'h11bb33dd || bus.qb !== 32'h11bb33dd) begin
      mismatched++;
      $display("FAIL lanes: qa=%h qb=%h expected 11bb33dd", bus.qa, bus.qb);
    end
    drive(1'b1, 1'b1, 4'h0, 8'd5, 8'd0, 8'd5, 32'hffffffff);
    compared++;
    if (bus.qb !== 32'h11bb33dd) begin
      mismatched++;
      $display("FAIL be_zero: qb=%h expected 11bb33dd", bus.qb);
    end
  endtask
  task automatic test_bypass();
    drive(1'b1, 1'b1, 4'hf, 8'd7, 8'd7, 8'd7, 32'h3c);
    compared++;
    if (bus.qa !== 32'h3c || bus.qb !== 32'h3c) begin
      mismatched++;
      $display("FAIL bypass_full: qa=%h qb=%h expected 3c", bus.qa, bus.qb);
    end
    drive(1'b1, 1'b0, 4'h0, 8'd0, 8'd7, 8'd7, 32'h0);
    compared++;
    if (bus.qa !== 32'h3c || bus.qb !== 32'h3c) begin
      mismatched++;
      $display("FAIL reread: qa=%h qb=%h expected 3c", bus.qa, bus.qb);
    end
    drive(1'b1, 1'b1, 4'b1000, 8'd5, 8'd5, 8'd7, 32'hffffffff);
    compared++;
    if (bus.qa !== 32'hffbb33dd || bus.qb !== 32'h3c) begin
      mismatched++;
      $display("FAIL bypass_lane: qa=%h qb=%h expected ffbb33dd 3c", bus.qa, bus.qb);
    end
  endtask
  task automatic test_hold();
    drive(1'b0, 1'b1, 4'hf, 8'd7, 8'd0, 8'd0, 32'h12345678);
    compared++;
    if (bus.qa !== 32'hffbb33dd || bus.qb !== 32'h3c) begin
      mismatched++;
      $display("FAIL ce_hold: qa=%h qb=%h expected ffbb33dd 3c", bus.qa, bus.qb);
    end
    drive(1'b1, 1'b0, 4'h0, 8'd0, 8'd7, 8'd5, 32'h0);
    compared++;
    if (bus.qa !== 32'h3c || bus.qb !== 32'hffbb33dd) begin
      mismatched++;
      $display("FAIL ce_nowrite: qa=%h qb=%h expected 3c ffbb33dd", bus.qa, bus.qb);
    end
  endtask
  task automatic test_random();
    logic [7:0] wa, ra, rb;
    for (int i = 0; i < 400; i++) begin
      wa = 8'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom());
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom()), 4'($urandom()), wa, ra, rb, $urandom());
      compared++;
      if (bus.qa !== exp_qa || bus.qb !== exp_qb) begin
        mismatched++;
        $display("FAIL random[%0d]: qa=%h qb=%h expected %h %h", i, bus.qa, bus.qb, exp_qa, exp_qb);
      end
    end
  endtask
  task automatic test_rst_mid_sweep();
    int n;
    rst = 1'b1;
    idle();
    cycle();
    rst = 1'b0;
    repeat (SWEEP > 0 ? 100 : 0) cycle();
    compared++;
    if (bus.busy !== (SWEEP > 0)) begin
      mismatched++;
      $display("FAIL mid_busy: busy=%b expected %b", bus.busy, SWEEP > 0);
    end
    rst = 1'b1;
    cycle();
    compared++;
    if (bus.qa !== 32'h0 || bus.qb !== 32'h0 || bus.busy !== (SWEEP > 0)) begin
      mismatched++;
      $display("FAIL mid_reset: qa=%h qb=%h busy=%b expected 0 0 %b", bus.qa, bus.qb, bus.busy, SWEEP > 0);
    end
    rst = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      cycle();
      n++;
    end
    compared++;
    if (n != SWEEP) begin
      mismatched++;
      $display("FAIL restart_cycles: got %0d expected %0d", n, SWEEP);
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_sweep_contents();
    test_fill();
    test_zero_addr();
    test_lanes();
    test_bypass();
    test_hold();
    test_random();
    test_rst_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/regfile_mem.md
# regfile_mem

Parametrised single-write / dual-read memory with a hard-wired zero location, byte-lane write enables, write-first read bypass and a post-reset clear sweep. Next generation of the datapath's single-port zero-at-address-0 memory, used as the register file in the datapath: two operands read per cycle, one result written back. Reads are synchronous, with one cycle of latency.

## Interface
Parameters:
- A, 8, address width
- D, 8, data width; must be a multiple of 8
- R, 256, number of words; must equal 2^A

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- ce  input  1  chip enable; gates reads and writes
- we  input  1  write enable; effective only when ce=1
- be  input  D/8  byte-lane enables for the write; bit i covers data[8i+7:8i]
- waddr  input  A  write address
- wdata  input  D  write data
- ra_addr  input  A  read port A address
- rb_addr  input  A  read port B address
- qa  output  D  read port A data, registered
- qb  output  D  read port B data, registered
- busy  output  1  high while the clear sweep runs; all ce activity is ignored

## Operation
- Address 0 is hard-wired zero: writes to waddr=0 are discarded, and reads of address 0 return 0.
- Write: on a clock edge with ce=1, we=1, busy=0 and waddr!=0, only the lanes with be[i]=1 update; other lanes keep their old value. A write with be=0 is a no-op.
- Read: on a clock edge with ce=1 and busy=0, qa/qb load the contents of ra_addr/rb_addr.
  - With ce=0 or busy=1, qa/qb hold their value.
  - Reads are independent of we.
- Write-first bypass: if a read address equals waddr (nonzero) in the same enabled write cycle, that port returns the merged word: new bytes in enabled lanes, old bytes elsewhere. Both ports may bypass at once.
- Clear sweep (state machine, when compiled in):
  - State CLEAR: writes 0 to address cnt and increments cnt each cycle. cnt runs from 1 to R-1 and does not wrap. busy=1.
  - Transition CLEAR -> READY after writing address R-1.
  - State READY: normal operation, busy=0. It is left only by rst.
- Reset: rst=1 forces state CLEAR, cnt=1, qa=0, qb=0, busy=1.
  - Reset asserted mid-sweep or mid-operation restarts the sweep from address 1.
  - Inputs are ignored while rst=1.

## Timing
- Read latency: 1 cycle, from the address sampled at edge N to qa/qb valid after edge N.
- Write visible to a non-bypassed read sampled at edge N+1 or later.
- Sweep duration: R-1 cycles after the first edge with rst=0; busy falls after edge R-1. For R=256, busy=1 for 255 cycles.
- Simultaneous events:
  - A write is issued together with reads of the same address on both ports: both ports return the merged data.
  - ce is asserted while busy=1: the request is dropped and not queued.
- Reset values: qa=0, qb=0, busy=1 (busy=0 when the sweep is compiled out).

## Configuration
- Macro REGFILE_MEM_CLEAR_EN.
- Defined: the clear sweep is present, as in Operation.
- Undefined:
  - No state machine; busy is tied to 0.
  - Memory contents after reset are undefined, except address 0, which still reads 0.
  - rst only clears qa/qb.
  - The block accepts traffic on the first cycle after reset.

## Structure
- Package regfile_mem_pkg:
  - State enum {CLEAR, READY}.
  - Constant ZERO_ADDR=0.
  - A function building the D-bit lane mask from be.
- One sub-module, regfile_mem_clear: sweep counter and state machine. Outputs busy, clear_we and clear_addr, and is instantiated only under REGFILE_MEM_CLEAR_EN.
- Top level holds the storage array, the write-port mux (sweep vs. user), the lane merge and the bypass compare.

## Test plan
- Reset release, D=8, R=256: busy=1 for exactly 255 cycles, qa=qb=0. Afterwards, reads of addresses 1, 128 and 255 return 0x00.
- Write 0xA5 to address 0, then read address 0 on both ports: qa=qb=0x00.
- D=32: write 0x11223344 to address 5, then write 0xAABBCCDD with be=4'b0101, then read: 0x11BB33DD.
- Same-cycle write of 0x3C to address 7 with ra_addr=rb_addr=7: qa=qb=0x3C on the next cycle. Reading address 7 again with no write also returns 0x3C.
- ce=1 with a write to address 9 issued while busy=1, then a read of address 9 after busy falls: 0x00. qa held its value during busy.
- rst pulsed 100 cycles into the sweep: busy stays high for a further 255 cycles from release, and qa=qb=0.
